// File: rtl/udp_pkg.sv
// Shared definitions for the UDP audio unpacker slice.
//   state_t  : byte FSM states (S_SEQ_HI, S_SEQ_LO, S_LO, S_HI)
//   SMP_W    : PCM sample width
//   CNT_W    : status counter width
//   sat_inc  : saturating increment for the status counters
package udp_pkg;

    localparam int unsigned SMP_W = 16;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        S_SEQ_HI,
        S_SEQ_LO,
        S_LO,
        S_HI
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/udp_audio_unpack_if.sv
// Byte-in / sample-out bus of the UDP audio unpacker.
//   rec_en, rec_data, rec_pkt_done, rec_byte_num : parser byte stream
//   smp_valid, smp_data, smp_ready               : sample handshake
// Modports: slave = unpacker side, master = parser/consumer side.
interface udp_audio_unpack_if;
    import udp_pkg::*;

    logic             rec_en;
    logic [7:0]       rec_data;
    logic             rec_pkt_done;
    logic [15:0]      rec_byte_num;
    logic             smp_valid;
    logic [SMP_W-1:0] smp_data;
    logic             smp_ready;

    modport slave (
        input  rec_en, rec_data, rec_pkt_done, rec_byte_num, smp_ready,
        output smp_valid, smp_data
    );

    modport master (
        output rec_en, rec_data, rec_pkt_done, rec_byte_num, smp_ready,
        input  smp_valid, smp_data
    );

endinterface

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO with a registered head word.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_wr_en      : push request (ignored when full unless popping)
//   i_wr_data    : push data
//   i_rd_en      : pop request (ignored when empty)
//   o_rd_data    : head word, valid while !o_empty, 0 after reset
//   o_full       : occupancy == DEPTH
//   o_empty      : occupancy == 0
//   o_level      : occupancy, AW+1 bits
module sync_fifo_fwft #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_head;

    logic             w_push;
    logic             w_pop;
    logic [AW-1:0]    w_rptr_next;
    logic [AW:0]      w_cnt_after_pop;

    assign o_full          = (r_count == (AW+1)'(DEPTH));
    assign o_empty         = (r_count == '0);
    assign w_pop           = i_rd_en && !o_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push          = i_wr_en && (!o_full || w_pop);
    assign w_rptr_next     = r_rptr + AW'(w_pop);
    assign w_cnt_after_pop = r_count - (AW+1)'(w_pop);

    assign o_rd_data = r_head;
    assign o_level   = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            r_rptr  <= w_rptr_next;
            r_count <= w_cnt_after_pop + (AW+1)'(w_push);
        end
    end

    // Head register: bypass the incoming word when it lands in an otherwise
    // empty FIFO, otherwise load the next stored word on a pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
        end else if (w_push && (w_cnt_after_pop == '0)) begin
            r_head <= i_wr_data;
        end else if (w_pop) begin
            r_head <= r_mem[w_rptr_next];
        end
    end

endmodule

// File: rtl/udp_audio_unpack.sv
// Receive-side UDP audio payload unpacker.
// Strips an optional big-endian 16-bit sequence header, assembles
// little-endian 16-bit PCM samples into a FWFT FIFO and reports errors.
// Optional feature macro: UDP_UNPACK_SEQ_EN (sequence header + tracking).
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus (slave) : rec_* byte stream in, smp_* valid/ready sample out
//   fifo_level  : FIFO occupancy
//   pkt_done    : 1-cycle pulse at the end of each packet
//   odd_err     : 1-cycle pulse, packet ended with a dangling byte
//   runt_err    : 1-cycle pulse, packet ended inside the header
//   seq_gap     : 1-cycle pulse, sequence number not as expected
//   lost_cnt    : saturating count of seq_gap events
//   ovf_cnt     : saturating count of samples dropped on a full FIFO
module udp_audio_unpack
    import udp_pkg::*;
#(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    udp_audio_unpack_if.slave   bus,
    output logic [AW:0]         fifo_level,
    output logic                pkt_done,
    output logic                odd_err,
    output logic                runt_err,
    output logic                seq_gap,
    output logic [CNT_W-1:0]    lost_cnt,
    output logic [CNT_W-1:0]    ovf_cnt
);

`ifdef UDP_UNPACK_SEQ_EN
    localparam state_t ST_START = S_SEQ_HI;
`else
    localparam state_t ST_START = S_LO;
`endif

    state_t           r_state;
    state_t           w_state_next;
    logic [7:0]       r_lo;
    logic             r_wr_en;
    logic [SMP_W-1:0] r_wr_data;
    logic             r_pkt_done;
    logic             r_odd;
    logic [CNT_W-1:0] r_ovf_cnt;

    logic             w_push;
    logic             w_lo_ld;
    logic             w_odd;
    logic             w_done;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_ovf;
    logic             w_unused;

    assign w_unused = ^bus.rec_byte_num;

`ifdef UDP_UNPACK_SEQ_EN
    logic [7:0]       r_seq_hi;
    logic [15:0]      r_expected;
    logic             r_first;
    logic             r_seq_gap;
    logic             r_runt;
    logic [CNT_W-1:0] r_lost_cnt;
    logic             w_seq_hi_ld;
    logic             w_seq_done;
    logic             w_runt;
    logic [15:0]      w_seq;

    assign w_seq = {r_seq_hi, bus.rec_data};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_START;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        w_lo_ld      = 1'b0;
        w_odd        = 1'b0;
        w_done       = 1'b0;
`ifdef UDP_UNPACK_SEQ_EN
        w_seq_hi_ld  = 1'b0;
        w_seq_done   = 1'b0;
        w_runt       = 1'b0;
`endif
        if (bus.rec_en) begin
            case (r_state)
`ifdef UDP_UNPACK_SEQ_EN
                S_SEQ_HI: begin
                    w_seq_hi_ld  = !bus.rec_pkt_done;
                    w_runt       = bus.rec_pkt_done;
                    w_state_next = S_SEQ_LO;
                end
                S_SEQ_LO: begin
                    w_seq_done   = 1'b1;
                    w_state_next = S_LO;
                end
`endif
                S_LO: begin
                    w_lo_ld      = 1'b1;
                    w_odd        = bus.rec_pkt_done;
                    w_state_next = S_HI;
                end
                S_HI: begin
                    w_push       = 1'b1;
                    w_state_next = S_LO;
                end
                default: w_state_next = ST_START;
            endcase
            if (bus.rec_pkt_done) begin
                w_done       = 1'b1;
                w_state_next = ST_START;
            end
        end
    end

    assign w_pop = bus.smp_valid && bus.smp_ready;
    assign w_ovf = r_wr_en && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lo       <= '0;
            r_wr_en    <= 1'b0;
            r_wr_data  <= '0;
            r_pkt_done <= 1'b0;
            r_odd      <= 1'b0;
            r_ovf_cnt  <= '0;
        end else begin
            if (w_lo_ld) begin
                r_lo <= bus.rec_data;
            end
            r_wr_en    <= w_push;
            r_wr_data  <= {bus.rec_data, r_lo};
            r_pkt_done <= w_done;
            r_odd      <= w_odd;
            if (w_ovf) begin
                r_ovf_cnt <= sat_inc(r_ovf_cnt);
            end
        end
    end

`ifdef UDP_UNPACK_SEQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seq_hi   <= '0;
            r_expected <= '0;
            r_first    <= 1'b1;
            r_seq_gap  <= 1'b0;
            r_runt     <= 1'b0;
            r_lost_cnt <= '0;
        end else begin
            r_seq_gap <= 1'b0;
            r_runt    <= w_runt;
            if (w_seq_hi_ld) begin
                r_seq_hi <= bus.rec_data;
            end
            if (w_seq_done) begin
                r_first    <= 1'b0;
                r_expected <= w_seq + 16'd1;
                if (!r_first && (w_seq != r_expected)) begin
                    r_seq_gap  <= 1'b1;
                    r_lost_cnt <= sat_inc(r_lost_cnt);
                end
            end
        end
    end

    assign seq_gap  = r_seq_gap;
    assign runt_err = r_runt;
    assign lost_cnt = r_lost_cnt;
`else
    assign seq_gap  = 1'b0;
    assign runt_err = 1'b0;
    assign lost_cnt = '0;
`endif

    assign pkt_done = r_pkt_done;
    assign odd_err  = r_odd;
    assign ovf_cnt  = r_ovf_cnt;

    sync_fifo_fwft #(
        .WIDTH (SMP_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (r_wr_en),
        .i_wr_data (r_wr_data),
        .i_rd_en   (bus.smp_ready),
        .o_rd_data (bus.smp_data),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (fifo_level)
    );

    assign bus.smp_valid = !w_empty;

endmodule

// File: tb/tb_udp_audio_unpack.sv
// Scoreboard bench for udp_audio_unpack (DEPTH=16). Works with or without
// UDP_UNPACK_SEQ_EN; expected flags are derived from the SEQ constant.
module tb_udp_audio_unpack;
    import udp_pkg::*;

`ifdef UDP_UNPACK_SEQ_EN
    localparam bit SEQ = 1'b1;
`else
    localparam bit SEQ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  fifo_level;
    logic        pkt_done, odd_err, runt_err, seq_gap;
    logic [15:0] lost_cnt, ovf_cnt;

    udp_audio_unpack_if bus();

    udp_audio_unpack #(.DEPTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .fifo_level (fifo_level),
        .pkt_done   (pkt_done),
        .odd_err    (odd_err),
        .runt_err   (runt_err),
        .seq_gap    (seq_gap),
        .lost_cnt   (lost_cnt),
        .ovf_cnt    (ovf_cnt)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  tx_q[$];
    logic [15:0] exp_smp[$];
    logic [2:0]  exp_rec[$];   // {odd, runt, gap}

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic add_seq(input logic [15:0] s);
        if (SEQ) begin
            tx_q.push_back(s[15:8]);
            tx_q.push_back(s[7:0]);
        end
    endtask

    task automatic add_smp(input logic [15:0] v, input bit expect_it);
        tx_q.push_back(v[7:0]);
        tx_q.push_back(v[15:8]);
        if (expect_it) exp_smp.push_back(v);
    endtask

    task automatic add_rec(input bit odd, input bit runt, input bit gap);
        exp_rec.push_back({odd, runt, gap});
    endtask

    // Sends tx_q back to back; last byte carries rec_pkt_done if with_done.
    task automatic send_q(input bit with_done);
        int unsigned n = tx_q.size();
        for (int unsigned i = 0; i < n; i++) begin
            bus.rec_en       = 1'b1;
            bus.rec_data     = tx_q[i];
            bus.rec_pkt_done = with_done && (i == n - 1);
            bus.rec_byte_num = 16'(n);
            @(posedge clk); #1;
        end
        bus.rec_en       = 1'b0;
        bus.rec_pkt_done = 1'b0;
        tx_q.delete();
    endtask

    task automatic seq_pkt(input logic [15:0] s, input logic [15:0] v, input bit gap);
        add_seq(s);
        add_smp(v, 1'b1);
        add_rec(1'b0, 1'b0, gap & SEQ);
        send_q(1'b1);
    endtask

    task automatic wait_drain(input string name);
        int unsigned n = 0;
        while ((bus.smp_valid || exp_smp.size() != 0 || exp_rec.size() != 0) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_pending"}, 32'(exp_smp.size() + exp_rec.size()), 32'd0);
        chk({name, "_level"}, 32'(fifo_level), 32'd0);
    endtask

    // Monitor: pops the scoreboards whenever the DUT presents a sample or a packet end.
    int unsigned gap_acc = 0;
    initial begin
        logic [15:0] e;
        logic [2:0]  r;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                gap_acc = 0;
            end else begin
                if (bus.smp_valid && bus.smp_ready) begin
                    n_checks++;
                    if (exp_smp.size() == 0) begin
                        n_errors++;
                        $display("FAIL smp_extra got=%h exp=none", bus.smp_data);
                    end else begin
                        e = exp_smp.pop_front();
                        if (bus.smp_data !== e) begin
                            n_errors++;
                            $display("FAIL smp_data got=%h exp=%h", bus.smp_data, e);
                        end
                    end
                end
                if (seq_gap) gap_acc++;
                if (pkt_done) begin
                    n_checks++;
                    if (exp_rec.size() == 0) begin
                        n_errors++;
                        $display("FAIL pkt_extra got=pkt_done exp=none");
                    end else begin
                        r = exp_rec.pop_front();
                        if ({odd_err, runt_err, gap_acc != 0} !== r) begin
                            n_errors++;
                            $display("FAIL pkt_flags got=%b exp=%b (odd,runt,gap)",
                                     {odd_err, runt_err, gap_acc != 0}, r);
                        end
                    end
                    gap_acc = 0;
                end else if (odd_err || runt_err) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL stray_err got=%b exp=00", {odd_err, runt_err});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rec_en       = 1'b0;
        bus.rec_data     = '0;
        bus.rec_pkt_done = 1'b0;
        bus.rec_byte_num = '0;
        bus.smp_ready    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.smp_valid), 32'd0);
        chk("rst_data",  32'(bus.smp_data),  32'd0);
        chk("rst_level", 32'(fifo_level),    32'd0);
        chk("rst_flags", 32'({pkt_done, odd_err, runt_err, seq_gap}), 32'd0);
        chk("rst_cnts",  {lost_cnt, ovf_cnt}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Two samples with latency probe after the first high byte.
        add_seq(16'h0001);
        tx_q.push_back(8'h34);
        tx_q.push_back(8'h12);
        exp_smp.push_back(16'h1234);
        exp_smp.push_back(16'hABCD);
        add_rec(1'b0, 1'b0, 1'b0);
        send_q(1'b0);
        chk("lat_n1_valid", 32'(bus.smp_valid), 32'd0);
        @(posedge clk); #1;
        chk("lat_n2_valid", 32'(bus.smp_valid), 32'd1);
        chk("lat_n2_level", 32'(fifo_level),    32'd1);
        chk("lat_n2_data",  32'(bus.smp_data),  32'h1234);
        tx_q.push_back(8'hCD);
        tx_q.push_back(8'hAB);
        send_q(1'b1);
        wait_drain("pkt1");

        // Reset in the middle of a packet: partial data is discarded.
        add_seq(16'h0002);
        tx_q.push_back(8'h77);
        send_q(1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_level", 32'(fifo_level),    32'd0);
        chk("mid_rst_valid", 32'(bus.smp_valid), 32'd0);

        // Sequence tracking: first packet after reset seeds, 8 and FFFF are gaps.
        seq_pkt(16'h0005, 16'h2211, 1'b0);
        seq_pkt(16'h0006, 16'h4433, 1'b0);
        seq_pkt(16'h0008, 16'h6655, 1'b1);
        @(posedge clk); #1;
        chk("lost_after_8", 32'(lost_cnt), SEQ ? 32'd1 : 32'd0);
        seq_pkt(16'h0009, 16'h8877, 1'b0);
        seq_pkt(16'hFFFF, 16'hAA99, 1'b1);
        seq_pkt(16'h0000, 16'hCCBB, 1'b0);
        wait_drain("seq");
        chk("lost_after_wrap", 32'(lost_cnt), SEQ ? 32'd2 : 32'd0);

        // Odd-length payload: 0x7F must never appear as a sample.
        add_seq(16'h0001);
        add_smp(16'h0001, 1'b1);
        tx_q.push_back(8'h7F);
        add_rec(1'b1, 1'b0, 1'b0);
        send_q(1'b1);
        wait_drain("odd");

        // One-byte packet: runt with header, dangling byte without.
        tx_q.push_back(8'hAA);
        add_rec(!SEQ, SEQ, 1'b0);
        send_q(1'b1);
        wait_drain("runt");

        // Expected sequence still 2 after the runt.
        add_seq(16'h0002);
        add_smp(16'h0002, 1'b1);
        add_smp(16'h0004, 1'b1);
        add_rec(1'b0, 1'b0, 1'b0);
        send_q(1'b1);
        wait_drain("post_runt");

        // Overflow: 20 samples into a 16-deep FIFO with the consumer stalled.
        bus.smp_ready = 1'b0;
        add_seq(16'h0003);
        for (int unsigned i = 0; i < 20; i++) begin
            add_smp(16'h0100 + 16'(i), i < 16);
        end
        add_rec(1'b0, 1'b0, 1'b0);
        send_q(1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("ovf_level", 32'(fifo_level), 32'd16);
        chk("ovf_cnt",   32'(ovf_cnt),    32'd4);
        chk("ovf_valid", 32'(bus.smp_valid), 32'd1);
        chk("ovf_head",  32'(bus.smp_data),  32'h0100);
        bus.smp_ready = 1'b1;
        wait_drain("ovf_drain");
        chk("final_lost", 32'(lost_cnt), SEQ ? 32'd2 : 32'd0);
        chk("final_ovf",  32'(ovf_cnt),  32'd4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
